// File: rtl/cache_request_issuer_if.sv
// Bundle of the CPU-side request, L1-side cache and response/statistics signals
// around cache_request_issuer. The master modport is the issuer's own view.
interface cache_request_issuer_if #(
  parameter int ADDR_LENGTH = 15,
  parameter int LAT_WIDTH   = 16
);
  logic                   reqValid;
  logic                   reqReady;
  logic                   reqWrite;
  logic [ADDR_LENGTH-1:0] reqAddr;
  logic [31:0]            reqData;

  logic [ADDR_LENGTH-1:0] cacheAddr;
  logic                   cacheEnable;
  logic                   cacheWrite;
  logic [31:0]            cacheDataOut;
  logic                   cacheComplete;
  logic [31:0]            cacheDataIn;

  logic                   respValid;
  logic                   respWrite;
  logic [31:0]            respData;
  logic [LAT_WIDTH-1:0]   respLatency;
  logic [LAT_WIDTH-1:0]   totalRequests;
  logic                   busy;

  modport master (
    input  reqValid, reqWrite, reqAddr, reqData, cacheComplete, cacheDataIn,
    output reqReady, cacheAddr, cacheEnable, cacheWrite, cacheDataOut,
           respValid, respWrite, respData, respLatency, totalRequests, busy
  );

  modport slave (
    output reqValid, reqWrite, reqAddr, reqData, cacheComplete, cacheDataIn,
    input  reqReady, cacheAddr, cacheEnable, cacheWrite, cacheDataOut,
           respValid, respWrite, respData, respLatency, totalRequests, busy
  );
endinterface

// File: rtl/cache_request_issuer.sv
// Buffers CPU requests in a small FIFO and issues them one at a time to the L1
// port with an enable-level handshake, reporting data, latency and a request count.
module cache_request_issuer #(
  parameter int ADDR_LENGTH = 15,
  parameter int DEPTH       = 4,
  parameter int LAT_WIDTH   = 16
) (
  input logic              clock,
  input logic              reset,
  cache_request_issuer_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic                   memWrite [DEPTH];
  logic [ADDR_LENGTH-1:0] memAddr  [DEPTH];
  logic [31:0]            memData  [DEPTH];

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;
  logic             reqReadyInt;
  logic             push;
  logic             pop;

  logic [1:0]             state;
  logic                   heldWrite;
  logic [ADDR_LENGTH-1:0] heldAddr;
  logic [31:0]            heldData;
  logic                   cacheEnableReg;
  logic [LAT_WIDTH-1:0]   latCnt;
  logic [LAT_WIDTH-1:0]   latNext;

  logic                 respValidReg;
  logic                 respWriteReg;
  logic [31:0]          respDataReg;
  logic [LAT_WIDTH-1:0] respLatencyReg;
  logic [LAT_WIDTH-1:0] totalReg;

  // Readiness comes from the registered count, so a pop frees a slot one cycle later.
  assign reqReadyInt = !reset && (count != FULL_COUNT);
  assign push        = bus.reqValid && reqReadyInt;
  assign pop         = (state == IDLE) && (count != '0);
  assign latNext     = (latCnt == '1) ? latCnt : latCnt + 1'b1;

  always_ff @(posedge clock) begin
    if (push) begin
      memWrite[wrPtr] <= bus.reqWrite;
      memAddr[wrPtr]  <= bus.reqAddr;
      memData[wrPtr]  <= bus.reqData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The latency counter holds (enable cycles - 1), so completion reports counter+1.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      heldWrite      <= 1'b0;
      heldAddr       <= '0;
      heldData       <= '0;
      cacheEnableReg <= 1'b0;
      latCnt         <= '0;
      respValidReg   <= 1'b0;
      respWriteReg   <= 1'b0;
      respDataReg    <= '0;
      respLatencyReg <= '0;
      totalReg       <= '0;
    end else begin
      respValidReg <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            heldWrite      <= memWrite[rdPtr];
            heldAddr       <= memAddr[rdPtr];
            heldData       <= memData[rdPtr];
            cacheEnableReg <= 1'b1;
            latCnt         <= '0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.cacheComplete) begin
            cacheEnableReg <= 1'b0;
            respValidReg   <= 1'b1;
            respWriteReg   <= heldWrite;
            respDataReg    <= heldWrite ? 32'h0 : bus.cacheDataIn;
            respLatencyReg <= latNext;
            totalReg       <= totalReg + 1'b1;
            state          <= GAP;
          end else begin
            latCnt <= latNext;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.reqReady      = reqReadyInt;
  assign bus.cacheAddr     = heldAddr;
  assign bus.cacheEnable   = cacheEnableReg;
  assign bus.cacheWrite    = heldWrite;
  assign bus.cacheDataOut  = heldData;
  assign bus.respValid     = respValidReg;
  assign bus.respWrite     = respWriteReg;
  assign bus.respData      = respDataReg;
  assign bus.respLatency   = respLatencyReg;
  assign bus.totalRequests = totalReg;
  assign bus.busy          = (state != IDLE) || (count != '0);
endmodule
